// File: rtl/reg_writeback.sv
// Register-file writeback queue: buffers integer/FP write requests in a small
// circular FIFO, drains them one per cycle into a registered write port, and
// reports pending-write hazards for two source-register lookups.
module reg_writeback #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_fp,
  input  logic        in_double,
  input  logic [4:0]  in_reg,
  input  logic [31:0] in_data_1,
  input  logic [31:0] in_data_2,
  input  logic        wb_stall,
  input  logic        flush,
  output logic        RegWrite,
  output logic        Fp,
  output logic        double,
  output logic [4:0]  write_reg,
  output logic [31:0] write_data_1,
  output logic [31:0] write_data_2,
  input  logic [4:0]  chk_reg_1,
  input  logic [4:0]  chk_reg_2,
  input  logic        chk_fp,
  output logic        hazard_1,
  output logic        hazard_2,
  output logic [3:0]  count,
  output logic        empty
);

  localparam int         PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] DEPTH_C = 4'(DEPTH);

  // Queue storage; every slot is visible to the hazard comparators.
  logic        mem_fp     [DEPTH];
  logic        mem_double [DEPTH];
  logic [4:0]  mem_reg    [DEPTH];
  logic [31:0] mem_data_1 [DEPTH];
  logic [31:0] mem_data_2 [DEPTH];

  logic [PW-1:0] head_reg, tail_reg;
  logic [3:0]    count_reg, count_next;

  // Output (write-port) stage.
  logic        regwrite_reg;
  logic        fp_reg;
  logic        double_reg;
  logic [4:0]  write_reg_reg;
  logic [31:0] write_data_1_reg;
  logic [31:0] write_data_2_reg;

  logic push_acc;
  logic enq;
  logic pop;

  // A request is accepted whenever there is room; integer $0 is accepted
  // but dropped because that register is hard-wired to zero.
  assign in_ready = (count_reg < DEPTH_C) && !flush;
  assign push_acc = in_valid && in_ready;
  assign enq      = push_acc && (in_fp || (in_reg != 5'd0));
  assign pop      = (count_reg != 4'd0) && !wb_stall && !flush;

  assign count = count_reg;
  assign empty = (count_reg == 4'd0);

  assign RegWrite     = regwrite_reg;
  assign Fp           = fp_reg;
  assign double       = double_reg;
  assign write_reg    = write_reg_reg;
  assign write_data_1 = write_data_1_reg;
  assign write_data_2 = write_data_2_reg;

  // Occupancy update: a simultaneous enqueue and pop leaves count unchanged.
  always_comb begin
    count_next = count_reg;
    case ({enq, pop})
      2'b10:   count_next = count_reg + 4'd1;
      2'b01:   count_next = count_reg - 4'd1;
      default: count_next = count_reg;
    endcase
  end

  // Slot writes on enqueue; double is only meaningful for FP requests.
  always_ff @(posedge clk) begin
    if (enq) begin
      mem_fp[tail_reg]     <= in_fp;
      mem_double[tail_reg] <= in_fp && in_double;
      mem_reg[tail_reg]    <= in_reg;
      mem_data_1[tail_reg] <= in_data_1;
      mem_data_2[tail_reg] <= in_data_2;
    end
  end

  // Head/tail pointers and count; flush empties the queue like reset does.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= 4'd0;
    end else begin
      if (enq) tail_reg <= tail_reg + PW'(1);
      if (pop) head_reg <= head_reg + PW'(1);
      count_reg <= count_next;
    end
  end

  // Output stage: strobe for exactly one cycle per pop, fields hold otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      regwrite_reg     <= 1'b0;
      fp_reg           <= 1'b0;
      double_reg       <= 1'b0;
      write_reg_reg    <= 5'd0;
      write_data_1_reg <= 32'd0;
      write_data_2_reg <= 32'd0;
    end else begin
      regwrite_reg <= pop;
      if (pop) begin
        fp_reg           <= mem_fp[head_reg];
        double_reg       <= mem_double[head_reg];
        write_reg_reg    <= mem_reg[head_reg];
        write_data_1_reg <= mem_data_1[head_reg];
        write_data_2_reg <= mem_data_2[head_reg];
      end
    end
  end

  // True when an entry writes c_reg in the requested file; the second
  // register of a double wraps modulo 32.
  function automatic logic reg_match(input logic       e_fp,
                                     input logic       e_dbl,
                                     input logic [4:0] e_reg,
                                     input logic       c_fp,
                                     input logic [4:0] c_reg);
    logic [4:0] e_reg_hi;
    e_reg_hi = e_reg + 5'd1;
    return (e_fp == c_fp) && ((e_reg == c_reg) || (e_dbl && (e_reg_hi == c_reg)));
  endfunction

  logic [DEPTH-1:0] hit_1, hit_2;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot
      logic [PW-1:0] offset;
      logic          occupied;
      // A slot is live when its distance from head is below the count.
      assign offset   = PW'(gi) - head_reg;
      assign occupied = (4'(offset) < count_reg);
      assign hit_1[gi] = occupied &&
                         reg_match(mem_fp[gi], mem_double[gi], mem_reg[gi], chk_fp, chk_reg_1);
      assign hit_2[gi] = occupied &&
                         reg_match(mem_fp[gi], mem_double[gi], mem_reg[gi], chk_fp, chk_reg_2);
    end
  endgenerate

  logic out_hit_1, out_hit_2;
  assign out_hit_1 = regwrite_reg &&
                     reg_match(fp_reg, double_reg, write_reg_reg, chk_fp, chk_reg_1);
  assign out_hit_2 = regwrite_reg &&
                     reg_match(fp_reg, double_reg, write_reg_reg, chk_fp, chk_reg_2);

  // Integer $0 never has a pending write, regardless of queue contents.
  assign hazard_1 = !(!chk_fp && (chk_reg_1 == 5'd0)) && ((|hit_1) || out_hit_1);
  assign hazard_2 = !(!chk_fp && (chk_reg_2 == 5'd0)) && ((|hit_2) || out_hit_2);

endmodule

// File: tb/tb_reg_writeback.sv
// Directed bench for reg_writeback: expected writes go into a scoreboard
// queue as requests are driven and are matched as RegWrite pulses appear.
module tb_reg_writeback;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_fp = 1'b0;
  logic        in_double = 1'b0;
  logic [4:0]  in_reg = 5'd0;
  logic [31:0] in_data_1 = 32'd0;
  logic [31:0] in_data_2 = 32'd0;
  logic        wb_stall = 1'b0;
  logic        flush = 1'b0;
  logic        RegWrite, Fp, double;
  logic [4:0]  write_reg;
  logic [31:0] write_data_1, write_data_2;
  logic [4:0]  chk_reg_1 = 5'd0;
  logic [4:0]  chk_reg_2 = 5'd0;
  logic        chk_fp = 1'b0;
  logic        hazard_1, hazard_2;
  logic [3:0]  count;
  logic        empty;

  typedef struct packed {
    logic        fp;
    logic        dbl;
    logic [4:0]  r;
    logic [31:0] d1;
    logic [31:0] d2;
  } wr_t;

  wr_t exp_q[$];
  int  tests_run = 0;
  int  tests_failed = 0;

  reg_writeback #(.DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_fp(in_fp), .in_double(in_double), .in_reg(in_reg),
    .in_data_1(in_data_1), .in_data_2(in_data_2),
    .wb_stall(wb_stall), .flush(flush),
    .RegWrite(RegWrite), .Fp(Fp), .double(double),
    .write_reg(write_reg), .write_data_1(write_data_1), .write_data_2(write_data_2),
    .chk_reg_1(chk_reg_1), .chk_reg_2(chk_reg_2), .chk_fp(chk_fp),
    .hazard_1(hazard_1), .hazard_2(hazard_2),
    .count(count), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic fp, input logic dbl,
                       input logic [4:0] r, input logic [31:0] d1, input logic [31:0] d2);
    in_valid  = v;
    in_fp     = fp;
    in_double = dbl;
    in_reg    = r;
    in_data_1 = d1;
    in_data_2 = d2;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
  endtask

  task automatic expect_wr(input logic fp, input logic dbl, input logic [4:0] r,
                           input logic [31:0] d1, input logic [31:0] d2);
    wr_t e;
    e.fp  = fp;
    e.dbl = dbl;
    e.r   = r;
    e.d1  = d1;
    e.d2  = d2;
    exp_q.push_back(e);
  endtask

  // Scoreboard: every RegWrite cycle must match the oldest expected write.
  always @(negedge clk) begin
    if (RegWrite === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_write", 32'(RegWrite), 32'd0);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        $display("[TB] write fp=%0d dbl=%0d reg=%0d d1=0x%0h d2=0x%0h",
                 Fp, double, write_reg, write_data_1, write_data_2);
        check("sb_fp",     32'(Fp),        32'(e.fp));
        check("sb_double", 32'(double),    32'(e.dbl));
        check("sb_reg",    32'(write_reg), 32'(e.r));
        check("sb_data_1", write_data_1,   e.d1);
        check("sb_data_2", write_data_2,   e.d2);
      end
    end
  end

  initial begin
    // Reset values
    idle();
    repeat (2) tick();
    check("rst_RegWrite", 32'(RegWrite), 32'd0);
    check("rst_Fp", 32'(Fp), 32'd0);
    check("rst_double", 32'(double), 32'd0);
    check("rst_write_reg", 32'(write_reg), 32'd0);
    check("rst_data_1", write_data_1, 32'd0);
    check("rst_data_2", write_data_2, 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    rst_n = 1'b1;
    tick();
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Single integer write: latency of two edges, one cycle wide
    drive(1'b1, 1'b0, 1'b0, 5'd5, 32'h1234, 32'd0);
    expect_wr(1'b0, 1'b0, 5'd5, 32'h1234, 32'd0);
    tick();
    idle();
    check("lat_edge1_RegWrite", 32'(RegWrite), 32'd0);
    check("lat_edge1_count", 32'(count), 32'd1);
    tick();
    check("lat_edge2_RegWrite", 32'(RegWrite), 32'd1);
    check("lat_edge2_reg", 32'(write_reg), 32'd5);
    check("lat_edge2_data", write_data_1, 32'h1234);
    tick();
    check("lat_edge3_RegWrite", 32'(RegWrite), 32'd0);

    // Fill under stall: fifth request rejected, then drain in order
    wb_stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 1'b0, 5'(10 + i), 32'h100 + 32'(i), 32'h200 + 32'(i));
      check("fill_in_ready", 32'(in_ready), 32'(i < 4));
      if (i < 4) expect_wr(1'b0, 1'b0, 5'(10 + i), 32'h100 + 32'(i), 32'h200 + 32'(i));
      tick();
    end
    idle();
    check("fill_count", 32'(count), 32'd4);
    check("fill_in_ready_full", 32'(in_ready), 32'd0);
    check("fill_no_write", 32'(RegWrite), 32'd0);
    wb_stall = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("drain_RegWrite", 32'(RegWrite), 32'd1);
      check("drain_order", 32'(write_reg), 32'(10 + k));
    end
    tick();
    check("drain_done_RegWrite", 32'(RegWrite), 32'd0);
    check("drain_done_empty", 32'(empty), 32'd1);

    // FP double to reg 31: second register wraps to 0 for hazard purposes
    wb_stall = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 5'd31, 32'hA, 32'hB);
    expect_wr(1'b1, 1'b1, 5'd31, 32'hA, 32'hB);
    tick();
    idle();
    chk_fp = 1'b1; chk_reg_1 = 5'd0; chk_reg_2 = 5'd31;
    #1;
    check("dbl_hazard_wrap", 32'(hazard_1), 32'd1);
    check("dbl_hazard_base", 32'(hazard_2), 32'd1);
    chk_reg_2 = 5'd1;
    #1;
    check("dbl_hazard_reg1", 32'(hazard_2), 32'd0);
    chk_fp = 1'b0; chk_reg_1 = 5'd31;
    #1;
    check("dbl_hazard_intfile", 32'(hazard_1), 32'd0);
    chk_fp = 1'b1; chk_reg_1 = 5'd0;
    wb_stall = 1'b0;
    tick();
    check("dbl_RegWrite", 32'(RegWrite), 32'd1);
    check("dbl_Fp", 32'(Fp), 32'd1);
    check("dbl_double", 32'(double), 32'd1);
    check("dbl_write_reg", 32'(write_reg), 32'd31);
    check("dbl_hazard_outstage", 32'(hazard_1), 32'd1);
    tick();
    check("dbl_after_RegWrite", 32'(RegWrite), 32'd0);
    check("dbl_after_hazard", 32'(hazard_1), 32'd0);

    // Integer $0: accepted but never queued or written
    chk_fp = 1'b0; chk_reg_1 = 5'd0;
    drive(1'b1, 1'b0, 1'b0, 5'd0, 32'hDEAD, 32'd0);
    tick();
    idle();
    check("r0_count", 32'(count), 32'd0);
    check("r0_empty", 32'(empty), 32'd1);
    check("r0_hazard", 32'(hazard_1), 32'd0);
    tick();
    check("r0_no_write", 32'(RegWrite), 32'd0);

    // Flush with three queued (one popped into the output stage) and a push
    wb_stall = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, 1'b0, 1'b0, 5'(i), 32'h300 + 32'(i), 32'd0);
      tick();
    end
    idle();
    expect_wr(1'b0, 1'b0, 5'd1, 32'h301, 32'd0);
    check("fl_count3", 32'(count), 32'd3);
    chk_fp = 1'b0; chk_reg_1 = 5'd2;
    #1;
    check("fl_hazard_queued", 32'(hazard_1), 32'd1);
    wb_stall = 1'b0;
    tick();
    check("fl_pop_RegWrite", 32'(RegWrite), 32'd1);
    check("fl_pop_count", 32'(count), 32'd2);
    flush = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 5'd9, 32'h999, 32'd0);
    #1;
    check("fl_in_ready", 32'(in_ready), 32'd0);
    tick();
    flush = 1'b0;
    idle();
    check("fl_count", 32'(count), 32'd0);
    check("fl_RegWrite", 32'(RegWrite), 32'd0);
    check("fl_empty", 32'(empty), 32'd1);
    check("fl_hazard_cleared", 32'(hazard_1), 32'd0);
    repeat (3) tick();

    // Reset mid-operation with queued entries and an active write
    wb_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b0, 5'(20 + i), 32'h400 + 32'(i), 32'h500 + 32'(i));
      tick();
    end
    idle();
    expect_wr(1'b0, 1'b0, 5'd20, 32'h400, 32'h500);
    wb_stall = 1'b0;
    tick();
    check("mr_RegWrite", 32'(RegWrite), 32'd1);
    check("mr_count", 32'(count), 32'd2);
    rst_n = 1'b0;
    tick();
    check("mr_rst_RegWrite", 32'(RegWrite), 32'd0);
    check("mr_rst_write_reg", 32'(write_reg), 32'd0);
    check("mr_rst_data_1", write_data_1, 32'd0);
    check("mr_rst_data_2", write_data_2, 32'd0);
    check("mr_rst_count", 32'(count), 32'd0);
    rst_n = 1'b1;
    chk_fp = 1'b0; chk_reg_1 = 5'd21; chk_reg_2 = 5'd22;
    tick();
    check("mr_in_ready", 32'(in_ready), 32'd1);
    check("mr_hazard_1", 32'(hazard_1), 32'd0);
    check("mr_hazard_2", 32'(hazard_2), 32'd0);
    repeat (4) tick();
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/reg_writeback.md
REG_WRITEBACK -- requirements
Module: reg_writeback

Interface
REQ-001 Parameter DEPTH, default 4, number of queued write requests (power of two, 2..8).
REQ-002 clk  in  1  system clock; all state updates on rising edge.
REQ-003 rst_n  in  1  synchronous, active-low reset, sampled on rising clk.
REQ-004 in_valid  in  1  write request present.
REQ-005 in_ready  out  1  queue can accept a request this cycle.
REQ-006 in_fp  in  1  request targets FP register file (0 = integer file).
REQ-007 in_double  in  1  FP double: write in_reg and in_reg+1 (ignored when in_fp=0).
REQ-008 in_reg  in  5  destination register index.
REQ-009 in_data_1 / in_data_2  in  32 each  data for in_reg / in_reg+1.
REQ-010 wb_stall  in  1  register-file write port unavailable this cycle.
REQ-011 flush  in  1  discard all queued and in-flight requests.
REQ-012 RegWrite, Fp, double  out  1 each  register-file write strobe and qualifiers.
REQ-013 write_reg  out  5;  write_data_1, write_data_2  out  32 each  register-file write address/data.
REQ-014 chk_reg_1, chk_reg_2  in  5 each;  chk_fp  in  1  source registers to test for pending writes.
REQ-015 hazard_1, hazard_2  out  1 each  pending write exists to chk_reg_1 / chk_reg_2.
REQ-016 count  out  4  entries queued (excludes output stage);  empty  out  1  count==0.

Function
REQ-017 Queue SHALL be a circular FIFO of DEPTH entries {fp, double, reg, data_1, data_2} with head/tail pointers wrapping modulo DEPTH.
REQ-018 in_ready SHALL equal (count < DEPTH) and not flush; no same-cycle push-through when full.
REQ-019 Push SHALL occur on a rising edge where in_valid & in_ready.
REQ-020 A push with in_fp=0 and in_reg=0 SHALL be accepted but not enqueued (integer $0 is never written).
REQ-021 in_double SHALL be stored as (in_fp & in_double).
REQ-022 Pop SHALL occur on a rising edge where count>0, wb_stall=0 and flush=0; head entry is loaded into the output stage.
REQ-023 Output stage SHALL be registered: RegWrite=1 for exactly the one cycle following a pop, with Fp/double/write_reg/write_data_* from that entry; otherwise RegWrite=0 and other outputs hold their last value.
REQ-024 Simultaneous push and pop SHALL leave count unchanged; order is strictly first-in first-out.
REQ-025 Latency: request pushed at edge N into an empty queue with wb_stall low SHALL appear with RegWrite=1 in the cycle after edge N+1.
REQ-026 wb_stall high SHALL hold the queue; the output stage SHALL drop RegWrite to 0 after its single cycle and not re-issue.
REQ-027 flush on an edge SHALL empty the queue (count=0, pointers reset), drop any same-edge push, and force RegWrite=0 the following cycle.
REQ-028 hazard_n SHALL be combinational: 1 when any queued entry, or the output stage while RegWrite=1, has fp==chk_fp and (reg==chk_reg_n, or double=1 and reg+1 (mod 32)==chk_reg_n).
REQ-029 hazard_n SHALL be 0 when chk_fp=0 and chk_reg_n=0.
REQ-030 Double writes to reg 31 SHALL wrap the second register to 0, consistent with 5-bit index arithmetic.

Reset
REQ-031 While rst_n=0 on an edge: count=0, head=tail=0, RegWrite=0, Fp=0, double=0, write_reg=0, write_data_1=write_data_2=0.
REQ-032 Reset mid-operation SHALL discard all queued entries; in_ready=1 and hazard_1=hazard_2=0 in the cycle after reset releases.

Verification
REQ-033 Single int push reg 5 data 0x1234 on empty queue -> RegWrite=1, Fp=0, write_reg=5, write_data_1=0x1234 exactly two edges later, one cycle wide.
REQ-034 Hold wb_stall=1, push 5 requests -> fifth rejected (in_ready=0, count=4); release stall -> four writes in push order on consecutive cycles.
REQ-035 FP double push reg 31 data 0xA/0xB -> Fp=1, double=1, write_reg=31; hazard_1=1 for chk_fp=1, chk_reg_1=0 while pending.
REQ-036 Int push reg 0 -> count stays 0, no RegWrite; chk_reg_1=0 gives hazard_1=0.
REQ-037 Queue 3 entries, assert flush with in_valid=1 -> count=0, RegWrite=0 next cycle, flushed request never written.
REQ-038 Assert rst_n=0 with 2 entries queued and RegWrite=1 -> all outputs at reset values on next cycle, no further writes after release.
